// File: rtl/float_mult_pkg.sv
// ----------------------------------------------------------------------------
// float_mult_pkg
// Shared types and constants for the pipelined FP64 multiplier:
//   - operand classification enum and the classify helper
//   - exponent bias, quiet-NaN pattern and signed exponent limits
//   - per-stage packed pipeline structs (S1 unpacked, S2 product, S3 packed)
// ----------------------------------------------------------------------------
package float_mult_pkg;

   localparam int FLEN = 64;
   localparam int NE   = 11;
   localparam int NF   = 52;
   // Internal exponent width: two spare bits keep ea+eb-BIAS(+carries) from wrapping.
   localparam int EW   = NE + 2;

   localparam logic signed [EW-1:0] BIAS     = $signed({3'b000, {(NE-1){1'b1}}});
   localparam logic signed [EW-1:0] EXP_ONE  = $signed({{(EW-1){1'b0}}, 1'b1});
   localparam logic signed [EW-1:0] EXP_ZERO = $signed({EW{1'b0}});
   localparam logic signed [EW-1:0] EXP_MAX  = $signed({2'b00, {NE{1'b1}}});
   localparam logic [FLEN-1:0]      QNAN     = 64'h7FF8_0000_0000_0000;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_t;

   // S1: operands split into fields, hidden bit restored.
   typedef struct packed {
      logic            valid;
      logic            sign;
      fp_class_t       cls_a;
      fp_class_t       cls_b;
      logic [NE-1:0]   ea;
      logic [NE-1:0]   eb;
      logic [NF:0]     ma;
      logic [NF:0]     mb;
   } s1_t;

   // S2: full-width mantissa product and biased exponent sum.
   typedef struct packed {
      logic                   valid;
      logic                   sign;
      fp_class_t              cls_a;
      fp_class_t              cls_b;
      logic signed [EW-1:0]   exp;
      logic [2*NF+1:0]        prod;
   } s2_t;

   // S3 (and optional output stage): packed result.
   typedef struct packed {
      logic            valid;
      logic [FLEN-1:0] res;
      logic            error;
   } s3_t;

   // Subnormals (exp==0) are deliberately classified as zero (flush-to-zero).
   function automatic fp_class_t fp_classify(input logic [NE-1:0] exp, input logic [NF-1:0] frac);
      fp_class_t cls;
      if (exp == {NE{1'b0}}) begin
         cls = FP_ZERO;
      end else if (exp == {NE{1'b1}}) begin
         if (frac == {NF{1'b0}}) begin
            cls = FP_INF;
         end else begin
            cls = FP_NAN;
         end
      end else begin
         cls = FP_NORM;
      end
      return cls;
   endfunction

endpackage

// File: rtl/float_mult_if.sv
// ----------------------------------------------------------------------------
// float_mult_if
// Request/response bundle of the multiplier.
//   a, b        operands, sampled when up_valid is high
//   up_valid    request strobe
//   res, error  product and invalid-result flag, valid with down_valid
//   down_valid  one-cycle strobe per request
//   busy        any request in flight
// master = requester (sequencing FSM), slave = multiplier.
// ----------------------------------------------------------------------------
interface float_mult_if;
   logic [float_mult_pkg::FLEN-1:0] a;
   logic [float_mult_pkg::FLEN-1:0] b;
   logic                            up_valid;
   logic [float_mult_pkg::FLEN-1:0] res;
   logic                            down_valid;
   logic                            busy;
   logic                            error;

   modport master (output a, b, up_valid, input res, down_valid, busy, error);
   modport slave  (input a, b, up_valid, output res, down_valid, busy, error);
endinterface

// File: rtl/float_mult_pipe_unpack.sv
// ----------------------------------------------------------------------------
// float_unpack
// Combinational split of an FP64 word.
//   word  input  FLEN   packed operand
//   sign  output 1      sign bit
//   exp   output NE     biased exponent
//   mant  output NF+1   mantissa with hidden bit (0 for zero/subnormal)
//   cls   output        fp_class_t classification
// ----------------------------------------------------------------------------
module float_unpack
   import float_mult_pkg::*;
(
   input  logic [FLEN-1:0] word,
   output logic            sign,
   output logic [NE-1:0]   exp,
   output logic [NF:0]     mant,
   output fp_class_t       cls
);

   assign sign = word[FLEN-1];
   assign exp  = word[FLEN-2:NF];
   assign mant = {(word[FLEN-2:NF] != {NE{1'b0}}), word[NF-1:0]};
   assign cls  = fp_classify(word[FLEN-2:NF], word[NF-1:0]);

endmodule

// File: rtl/float_mult_pipe.sv
// ----------------------------------------------------------------------------
// float_mult_pipe
// Pipelined FP64 multiplier, one request per cycle, no backpressure.
//   clk   input  clock
//   rst   input  synchronous active-high reset, flushes all in-flight requests
//   bus   float_mult_if.slave (a, b, up_valid -> res, down_valid, busy, error)
// Stages: S1 unpack/classify, S2 mantissa product + exponent sum,
// S3 normalize/round(RNE)/pack. Latency 3 cycles.
// Build option FLOAT_MULT_OUT_REG_EN adds an output register stage after S3
// (latency 4, results identical).
// ----------------------------------------------------------------------------
module float_mult_pipe
   import float_mult_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   float_mult_if.slave  bus
);

   logic            sa_s, sb_s;
   logic [NE-1:0]   ea_s, eb_s;
   logic [NF:0]     ma_s, mb_s;
   fp_class_t       ca_s, cb_s;

   s1_t s1_r;
   s2_t s2_r;
   s3_t s3_r;

   float_unpack u_unpack_a (.word(bus.a), .sign(sa_s), .exp(ea_s), .mant(ma_s), .cls(ca_s));
   float_unpack u_unpack_b (.word(bus.b), .sign(sb_s), .exp(eb_s), .mant(mb_s), .cls(cb_s));

   // S1 register: capture unpacked operands and the request strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= '0;
      end else begin
         s1_r.valid <= bus.up_valid;
         s1_r.sign  <= sa_s ^ sb_s;
         s1_r.cls_a <= ca_s;
         s1_r.cls_b <= cb_s;
         s1_r.ea    <= ea_s;
         s1_r.eb    <= eb_s;
         s1_r.ma    <= ma_s;
         s1_r.mb    <= mb_s;
      end
   end

   // S2 register: mantissa product and signed biased exponent sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_r <= '0;
      end else begin
         s2_r.valid <= s1_r.valid;
         s2_r.sign  <= s1_r.sign;
         s2_r.cls_a <= s1_r.cls_a;
         s2_r.cls_b <= s1_r.cls_b;
         s2_r.exp   <= $signed({2'b00, s1_r.ea}) + $signed({2'b00, s1_r.eb}) - BIAS;
         s2_r.prod  <= {{(NF+1){1'b0}}, s1_r.ma} * {{(NF+1){1'b0}}, s1_r.mb};
      end
   end

   // norm_s holds the product with its leading one shifted out of view (bit 2NF+1 implied).
   logic [2*NF:0]          norm_s;
   logic signed [EW-1:0]   exp_n_s, exp_f_s;
   logic [NF-1:0]          frac_s;
   logic                   guard_s, rnd_s, sticky_s, rup_s;
   logic [NF:0]            frac_rnd_s;
   logic [FLEN-1:0]        res_s;
   logic                   err_s;
   logic                   nan_s, inf_s, zero_s;

   // S3 combinational: normalize, round to nearest even, resolve specials, pack.
   always_comb begin
      norm_s     = {(2*NF+1){1'b0}};
      exp_n_s    = s2_r.exp;
      res_s      = {FLEN{1'b0}};
      err_s      = 1'b0;
      if (s2_r.prod[2*NF+1]) begin
         norm_s  = s2_r.prod[2*NF:0];
         exp_n_s = s2_r.exp + EXP_ONE;
      end else begin
         norm_s  = {s2_r.prod[2*NF-1:0], 1'b0};
         exp_n_s = s2_r.exp;
      end
      frac_s     = norm_s[2*NF:NF+1];
      guard_s    = norm_s[NF];
      rnd_s      = norm_s[NF-1];
      sticky_s   = |norm_s[NF-2:0];
      rup_s      = guard_s & (rnd_s | sticky_s | frac_s[0]);
      frac_rnd_s = {1'b0, frac_s} + {{NF{1'b0}}, rup_s};
      // Carry-out leaves frac_rnd_s[NF-1:0] at zero, so only the exponent moves.
      if (frac_rnd_s[NF]) begin
         exp_f_s = exp_n_s + EXP_ONE;
      end else begin
         exp_f_s = exp_n_s;
      end

      nan_s  = (s2_r.cls_a == FP_NAN)  | (s2_r.cls_b == FP_NAN);
      inf_s  = (s2_r.cls_a == FP_INF)  | (s2_r.cls_b == FP_INF);
      zero_s = (s2_r.cls_a == FP_ZERO) | (s2_r.cls_b == FP_ZERO);

      if (nan_s || (inf_s && zero_s)) begin
         res_s = QNAN;
         err_s = 1'b1;
      end else if (inf_s) begin
         res_s = {s2_r.sign, {NE{1'b1}}, {NF{1'b0}}};
         err_s = 1'b1;
      end else if (zero_s) begin
         res_s = {s2_r.sign, {(FLEN-1){1'b0}}};
         err_s = 1'b0;
      end else if (exp_f_s >= EXP_MAX) begin
         res_s = {s2_r.sign, {NE{1'b1}}, {NF{1'b0}}};
         err_s = 1'b1;
      end else if (exp_f_s <= EXP_ZERO) begin
         res_s = {s2_r.sign, {(FLEN-1){1'b0}}};
         err_s = 1'b0;
      end else begin
         res_s = {s2_r.sign, exp_f_s[NE-1:0], frac_rnd_s[NF-1:0]};
         err_s = 1'b0;
      end
   end

   // S3 register: result is loaded only for a valid request, otherwise held.
   always_ff @(posedge clk) begin
      if (rst) begin
         s3_r <= '0;
      end else begin
         s3_r.valid <= s2_r.valid;
         if (s2_r.valid) begin
            s3_r.res   <= res_s;
            s3_r.error <= err_s;
         end
      end
   end

`ifdef FLOAT_MULT_OUT_REG_EN
   s3_t s4_r;

   // Optional output stage: plain retiming copy of S3 with the same hold behaviour.
   always_ff @(posedge clk) begin
      if (rst) begin
         s4_r <= '0;
      end else begin
         s4_r.valid <= s3_r.valid;
         if (s3_r.valid) begin
            s4_r.res   <= s3_r.res;
            s4_r.error <= s3_r.error;
         end
      end
   end

   assign bus.res        = s4_r.res;
   assign bus.error      = s4_r.error;
   assign bus.down_valid = s4_r.valid;
   assign bus.busy       = s1_r.valid | s2_r.valid | s3_r.valid | s4_r.valid;
`else
   assign bus.res        = s3_r.res;
   assign bus.error      = s3_r.error;
   assign bus.down_valid = s3_r.valid;
   assign bus.busy       = s1_r.valid | s2_r.valid | s3_r.valid;
`endif

endmodule
